// File: rtl/mips_pkg.sv
// Shared MIPS32 core definitions: datapath widths, writeback-source
// encodings and the EX/MEM payload layout at the default widths.
package mips_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        MTR_ALU = 2'd0,
        MTR_MEM = 2'd1,
        MTR_PC  = 2'd2
    } mem_to_reg_e;

    // Field order matches the packing used by ex_mem_skid (MSB first).
    typedef struct packed {
        logic                  branch;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        logic [1:0]            mem_to_reg;
        logic [XLEN-1:0]       jmp_addr;
        logic                  z;
        logic [XLEN-1:0]       pc_value;
        logic [XLEN-1:0]       result;
        logic [XLEN-1:0]       rt;
        logic [REG_ADDR_W-1:0] reg_dst;
    } ex_mem_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Valid/ready pipeline slot for an opaque payload. With SKID=1 a second
// entry absorbs one beat so in_ready is a pure register output; with SKID=0
// the slot is a single entry whose in_ready looks through to out_ready.
module pipe_skid_buf #(
    parameter int WIDTH = 8,
    parameter bit SKID  = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic             main_valid, main_valid_nxt;
    logic             skid_valid, skid_valid_nxt;
    logic [WIDTH-1:0] main_data, main_data_nxt;
    logic [WIDTH-1:0] skid_data, skid_data_nxt;
    logic             accept;
    logic             pop;

    // Handshake: registered ready in skid mode, look-through ready otherwise.
    always_comb begin
        if (SKID) begin
            in_ready = !skid_valid;
        end else begin
            in_ready = !main_valid || out_ready;
        end
        accept = in_valid && in_ready;
        pop    = main_valid && out_ready;
    end

    // Next-entry logic: flush wins, skid refills main on pop, new beats land
    // in main when it frees up and in skid otherwise so order is preserved.
    always_comb begin
        main_valid_nxt = main_valid;
        skid_valid_nxt = skid_valid;
        main_data_nxt  = main_data;
        skid_data_nxt  = skid_data;
        if (flush) begin
            main_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
        end else begin
            if (pop) begin
                if (skid_valid) begin
                    main_data_nxt  = skid_data;
                    skid_valid_nxt = 1'b0;
                end else begin
                    main_valid_nxt = 1'b0;
                end
            end
            if (accept) begin
                if (!main_valid || (pop && !skid_valid)) begin
                    main_data_nxt  = in_data;
                    main_valid_nxt = 1'b1;
                end else if (SKID) begin
                    skid_data_nxt  = in_data;
                    skid_valid_nxt = 1'b1;
                end
            end
        end
    end

    // Entry registers; reset drops everything immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else begin
            main_valid <= main_valid_nxt;
            skid_valid <= skid_valid_nxt;
            main_data  <= main_data_nxt;
            skid_data  <= skid_data_nxt;
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register with valid/ready handshake, optional skid entry,
// synchronous flush and bubble gating of the side-effecting control bits.
module ex_mem_skid
    import mips_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit SKID       = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  branch_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  reg_write_in,
    input  logic [1:0]            mem_to_reg_in,
    input  logic [XLEN-1:0]       jmp_addr,
    input  logic [XLEN-1:0]       pc_value_in,
    input  logic [XLEN-1:0]       result_in,
    input  logic [XLEN-1:0]       rt_in,
    input  logic                  z_in,
    input  logic [REG_ADDR_W-1:0] reg_dst_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  branch_out,
    output logic                  mem_read_out,
    output logic                  mem_write_out,
    output logic                  reg_write_out,
    output logic [1:0]            mem_to_reg_out,
    output logic [XLEN-1:0]       jmp_addr_out,
    output logic                  z_out,
    output logic [XLEN-1:0]       pc_value_out,
    output logic [XLEN-1:0]       result_out,
    output logic [XLEN-1:0]       rt_out,
    output logic [REG_ADDR_W-1:0] reg_dst_out,
    output logic [1:0]            occupancy
);

    localparam int PAYLOAD_W = 7 + 4 * XLEN + REG_ADDR_W;

    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 held_branch;
    logic                 held_mem_read;
    logic                 held_mem_write;
    logic                 held_reg_write;

    // Same field order as mips_pkg::ex_mem_payload_t, but sized by the
    // module parameters so non-default widths still pack correctly.
    assign in_payload = {branch_in, mem_read_in, mem_write_in, reg_write_in,
                         mem_to_reg_in, jmp_addr, z_in, pc_value_in,
                         result_in, rt_in, reg_dst_in};

    pipe_skid_buf #(
        .WIDTH (PAYLOAD_W),
        .SKID  (SKID)
    ) u_buf (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload),
        .occupancy (occupancy)
    );

    assign {held_branch, held_mem_read, held_mem_write, held_reg_write,
            mem_to_reg_out, jmp_addr_out, z_out, pc_value_out,
            result_out, rt_out, reg_dst_out} = out_payload;

    // A bubble must never branch, touch memory or write the register file.
    always_comb begin
        branch_out    = out_valid && held_branch;
        mem_read_out  = out_valid && held_mem_read;
        mem_write_out = out_valid && held_mem_write;
        reg_write_out = out_valid && held_reg_write;
    end

endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid: a skid build and a single-entry build share the
// same upstream stimulus; each is compared every cycle against a queue model.
module tb_ex_mem_skid;

    typedef struct packed {
        logic        branch;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [1:0]  mem_to_reg;
        logic [31:0] jmp_addr;
        logic        z;
        logic [31:0] pc_value;
        logic [31:0] result;
        logic [31:0] rt;
        logic [4:0]  reg_dst;
    } pkt_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    pkt_t cur = '0;

    int n_compared = 0;
    int n_mismatched = 0;

    logic        in_ready_s1, out_valid_s1, branch_s1, mem_read_s1, mem_write_s1, reg_write_s1, z_s1;
    logic [1:0]  mtr_s1, occ_s1;
    logic [31:0] jmp_s1, pc_s1, result_s1, rt_s1;
    logic [4:0]  rd_s1;
    logic        in_ready_s0, out_valid_s0, branch_s0, mem_read_s0, mem_write_s0, reg_write_s0, z_s0;
    logic [1:0]  mtr_s0, occ_s0;
    logic [31:0] jmp_s0, pc_s0, result_s0, rt_s0;
    logic [4:0]  rd_s0;
    pkt_t        act1, act0;

    assign act1 = {branch_s1, mem_read_s1, mem_write_s1, reg_write_s1, mtr_s1, jmp_s1, z_s1, pc_s1, result_s1, rt_s1, rd_s1};
    assign act0 = {branch_s0, mem_read_s0, mem_write_s0, reg_write_s0, mtr_s0, jmp_s0, z_s0, pc_s0, result_s0, rt_s0, rd_s0};

    always #5 clock = ~clock;

    ex_mem_skid #(.XLEN(32), .REG_ADDR_W(5), .SKID(1'b1)) dut_skid (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_s1),
        .branch_in(cur.branch), .mem_read_in(cur.mem_read), .mem_write_in(cur.mem_write),
        .reg_write_in(cur.reg_write), .mem_to_reg_in(cur.mem_to_reg), .jmp_addr(cur.jmp_addr),
        .pc_value_in(cur.pc_value), .result_in(cur.result), .rt_in(cur.rt), .z_in(cur.z),
        .reg_dst_in(cur.reg_dst),
        .out_valid(out_valid_s1), .out_ready(out_ready),
        .branch_out(branch_s1), .mem_read_out(mem_read_s1), .mem_write_out(mem_write_s1),
        .reg_write_out(reg_write_s1), .mem_to_reg_out(mtr_s1), .jmp_addr_out(jmp_s1),
        .z_out(z_s1), .pc_value_out(pc_s1), .result_out(result_s1), .rt_out(rt_s1),
        .reg_dst_out(rd_s1), .occupancy(occ_s1)
    );

    ex_mem_skid #(.XLEN(32), .REG_ADDR_W(5), .SKID(1'b0)) dut_single (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_s0),
        .branch_in(cur.branch), .mem_read_in(cur.mem_read), .mem_write_in(cur.mem_write),
        .reg_write_in(cur.reg_write), .mem_to_reg_in(cur.mem_to_reg), .jmp_addr(cur.jmp_addr),
        .pc_value_in(cur.pc_value), .result_in(cur.result), .rt_in(cur.rt), .z_in(cur.z),
        .reg_dst_in(cur.reg_dst),
        .out_valid(out_valid_s0), .out_ready(out_ready),
        .branch_out(branch_s0), .mem_read_out(mem_read_s0), .mem_write_out(mem_write_s0),
        .reg_write_out(reg_write_s0), .mem_to_reg_out(mtr_s0), .jmp_addr_out(jmp_s0),
        .z_out(z_s0), .pc_value_out(pc_s0), .result_out(result_s0), .rt_out(rt_s0),
        .reg_dst_out(rd_s0), .occupancy(occ_s0)
    );

    // Model state: FIFO contents per build plus the last entry that sat at the head.
    pkt_t q1[$];
    pkt_t q0[$];
    pkt_t last1 = '0;
    pkt_t last0 = '0;

    task automatic check_int(input string name, input int act, input int exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_pkt(input string name, input pkt_t act, input pkt_t exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic pkt_t gate(input pkt_t p, input bit v);
        pkt_t g;
        g = p;
        if (!v) begin
            g.branch    = 1'b0;
            g.mem_read  = 1'b0;
            g.mem_write = 1'b0;
            g.reg_write = 1'b0;
        end
        return g;
    endfunction

    function automatic pkt_t mk(input logic [31:0] r, input logic [3:0] ctrl);
        pkt_t p;
        p.branch     = ctrl[3];
        p.mem_read   = ctrl[2];
        p.mem_write  = ctrl[1];
        p.reg_write  = ctrl[0];
        p.mem_to_reg = 2'(r % 3);
        p.jmp_addr   = r + 32'h100;
        p.z          = r[0];
        p.pc_value   = r << 2;
        p.result     = r;
        p.rt         = ~r;
        p.reg_dst    = r[4:0];
        return p;
    endfunction

    // Queue model: a bounded FIFO (depth 2 or 1) with flush and async reset.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q1.delete();
            q0.delete();
            last1 <= '0;
            last0 <= '0;
        end else begin
            bit acc1, pop1, acc0, pop0;
            acc1 = in_valid && (q1.size() < 2);
            pop1 = (q1.size() != 0) && out_ready;
            acc0 = in_valid && ((q0.size() == 0) || out_ready);
            pop0 = (q0.size() != 0) && out_ready;
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (pop1) void'(q1.pop_front());
                if (acc1) q1.push_back(cur);
                if (pop0) void'(q0.pop_front());
                if (acc0) q0.push_back(cur);
            end
            if (q1.size() != 0) last1 <= q1[0];
            if (q0.size() != 0) last0 <= q0[0];
        end
    end

    // Per-cycle comparison of both builds against the model.
    always @(negedge clock) begin
        check_int("s1_in_ready", int'(in_ready_s1), int'(q1.size() < 2));
        check_int("s1_out_valid", int'(out_valid_s1), int'(q1.size() != 0));
        check_int("s1_occupancy", int'(occ_s1), q1.size());
        check_pkt("s1_fields", act1, gate(last1, q1.size() != 0));
        check_int("s0_in_ready", int'(in_ready_s0), int'((q0.size() == 0) || out_ready));
        check_int("s0_out_valid", int'(out_valid_s0), int'(q0.size() != 0));
        check_int("s0_occupancy", int'(occ_s0), q0.size());
        check_pkt("s0_fields", act0, gate(last0, q0.size() != 0));
    end

    task automatic apply_stimulus(input bit v, input logic [31:0] r, input logic [3:0] ctrl,
                                  input bit ordy, input bit fl);
        @(posedge clock);
        #1;
        in_valid  = v;
        cur       = mk(r, ctrl);
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    initial begin
        $display("[TB] start");
        #1 reset = 1'b1;
        #20;
        check_int("rst_out_valid", int'(out_valid_s1), 0);
        check_int("rst_in_ready_s1", int'(in_ready_s1), 1);
        check_int("rst_in_ready_s0", int'(in_ready_s0), 1);
        check_pkt("rst_outputs", act1, '0);
        #2 reset = 1'b0;

        // Streaming: result k appears one cycle after it is presented.
        for (int k = 1; k <= 8; k++) begin
            apply_stimulus(1'b1, 32'(k), 4'b0001, 1'b1, 1'b0);
            if (k >= 2) begin
                check_int("stream_result_s1", int'(result_s1), k - 1);
                check_int("stream_valid_s1", int'(out_valid_s1), 1);
                check_int("stream_result_s0", int'(result_s0), k - 1);
            end
        end
        apply_stimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);
        check_int("stream_last", int'(result_s1), 8);
        apply_stimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);
        check_int("stream_drained", int'(out_valid_s1), 0);

        // Backpressure: A,B fill both entries, C waits for in_ready.
        apply_stimulus(1'b1, 32'hA, 4'b0011, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'hB, 4'b0000, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'hC, 4'b0000, 1'b0, 1'b0);
        check_int("bp_in_ready", int'(in_ready_s1), 0);
        check_int("bp_occ_full", int'(occ_s1), 2);
        check_int("bp_head_a", int'(result_s1), 32'hA);
        apply_stimulus(1'b1, 32'hC, 4'b0000, 1'b1, 1'b0);
        check_int("bp_still_full", int'(occ_s1), 2);
        check_int("bp_still_a", int'(result_s1), 32'hA);
        apply_stimulus(1'b1, 32'hC, 4'b0000, 1'b1, 1'b0);
        check_int("bp_head_b", int'(result_s1), 32'hB);
        check_int("bp_occ_one", int'(occ_s1), 1);
        check_int("bp_ready_again", int'(in_ready_s1), 1);
        apply_stimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);
        check_int("bp_head_c", int'(result_s1), 32'hC);
        apply_stimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);
        check_int("bp_empty", int'(out_valid_s1), 0);
        check_int("bp_hold_c", int'(result_s1), 32'hC);

        // Flush with a simultaneous accept drops everything.
        apply_stimulus(1'b1, 32'hD, 4'b0011, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'hE, 4'b0000, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'hF, 4'b0011, 1'b0, 1'b1);
        check_int("fl_occ_before", int'(occ_s1), 2);
        apply_stimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0);
        check_int("fl_out_valid", int'(out_valid_s1), 0);
        check_int("fl_occ", int'(occ_s1), 0);
        check_int("fl_mem_write", int'(mem_write_s1), 0);
        check_int("fl_reg_write", int'(reg_write_s1), 0);
        check_int("fl_out_valid_s0", int'(out_valid_s0), 0);

        // Bubble gating after the last entry leaves.
        apply_stimulus(1'b1, 32'h5A, 4'b0011, 1'b0, 1'b0);
        apply_stimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);
        check_int("bub_reg_write_live", int'(reg_write_s1), 1);
        check_int("bub_mem_write_live", int'(mem_write_s1), 1);
        apply_stimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0);
        check_int("bub_reg_write", int'(reg_write_s1), 0);
        check_int("bub_mem_write", int'(mem_write_s1), 0);
        check_int("bub_result_hold", int'(result_s1), 32'h5A);

        // Single-entry build: ready looks through to out_ready.
        apply_stimulus(1'b1, 32'h11, 4'b0000, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h22, 4'b0000, 1'b0, 1'b0);
        check_int("s0_ready_low", int'(in_ready_s0), 0);
        check_int("s0_head_11", int'(result_s0), 32'h11);
        apply_stimulus(1'b1, 32'h22, 4'b0000, 1'b1, 1'b0);
        check_int("s0_ready_high", int'(in_ready_s0), 1);
        apply_stimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);
        check_int("s0_head_22", int'(result_s0), 32'h22);
        check_int("s0_valid", int'(out_valid_s0), 1);
        check_int("s0_occ", int'(occ_s0), 1);

        // Reset in the middle of a stall.
        apply_stimulus(1'b1, 32'h31, 4'b0001, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h32, 4'b0001, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h33, 4'b0001, 1'b0, 1'b0);
        check_int("mr_occ_full", int'(occ_s1), 2);
        #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check_int("mr_out_valid", int'(out_valid_s1), 0);
        check_int("mr_occ", int'(occ_s1), 0);
        check_int("mr_in_ready_s1", int'(in_ready_s1), 1);
        check_int("mr_in_ready_s0", int'(in_ready_s0), 1);
        check_pkt("mr_outputs_s1", act1, '0);
        check_pkt("mr_outputs_s0", act0, '0);
        #20 reset = 1'b0;

        // Recovery after reset.
        apply_stimulus(1'b1, 32'h77, 4'b1100, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);
        check_int("post_rst_result", int'(result_s1), 32'h77);
        apply_stimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid.md
# ex_mem_skid

Parametrised EX/MEM pipeline register for the MIPS32 core, successor to the fixed `ex_mem` latch. It adds a valid/ready handshake with an optional one-entry skid buffer, a synchronous flush and automatic bubble insertion, so the memory stage can stall without combinational ready paths back into EX. It sits between the ALU/branch-target logic (EX) and data memory (MEM).

## Interface
- `XLEN`, 32, width of jmp_addr, pc_value, result, rt
- `REG_ADDR_W`, 5, width of reg_dst
- `SKID`, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single entry, in_ready = !out_valid || out_ready

Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `flush`  in  1  synchronous kill of all held entries (branch taken / exception)
- `in_valid`  in  1  EX presents a valid instruction
- `in_ready`  out  1  stage can accept this cycle
- `branch_in`, `mem_read_in`, `mem_write_in`, `reg_write_in`  in  1 each  control bits
- `mem_to_reg_in`  in  2  writeback source select
- `jmp_addr`, `pc_value_in`, `result_in`, `rt_in`  in  XLEN each  datapath
- `z_in`  in  1  ALU zero flag
- `reg_dst_in`  in  REG_ADDR_W  destination register
- `out_valid`  out  1  MEM side holds a valid instruction
- `out_ready`  in  1  MEM consumes this cycle
- `branch_out`, `mem_read_out`, `mem_write_out`, `reg_write_out`, `mem_to_reg_out`, `jmp_addr_out`, `z_out`, `pc_value_out`, `result_out`, `rt_out`, `reg_dst_out`  out  same widths as inputs
- `occupancy`  out  2  entries held (0..2; max 1 when SKID=0)

## Operation
- Accept = in_valid && in_ready; pop = out_valid && out_ready.
- Entries: main (drives outputs), skid (SKID=1 only).
- Accept, main empty or popping: payload -> main; main valid.
- Accept, main full and not popping (SKID=1): payload -> skid; skid valid.
- Pop with skid valid: skid -> main; skid cleared. Simultaneous accept lands in skid.
- in_ready (SKID=1) = !skid_valid, purely registered. in_ready (SKID=0) = !out_valid || out_ready.
- Bubble gating: when out_valid=0, branch_out, mem_read_out, mem_write_out, reg_write_out forced 0; datapath outputs hold last main contents.
- flush: both valid bits cleared at the edge; an accept in the same cycle is dropped. Flush has priority over accept and pop.
- No payload arithmetic; all fields are passed bit-exact.

## Timing
- Reset: all valid bits 0, all payload registers 0, out_valid=0, occupancy=0, all *_out=0. in_ready=1 (both modes).
- Latency: accept at edge N -> out_valid and fields visible after edge N, i.e. consumable in cycle N+1.
- Throughput: 1 per cycle with out_ready held high.
- Full (SKID=1, occupancy=2): in_ready=0 in the next cycle; upstream must hold its data.
- Reset asserted mid-stall: entries lost immediately, no pop reported.
- Order is preserved: the main entry always pops before the skid entry.

## Structure
- `mips_pkg`: XLEN, REG_ADDR_W, mem_to_reg encodings (MTR_ALU=0, MTR_MEM=1, MTR_PC=2), packed typedef `ex_mem_payload_t` holding all fields.
- Sub-module `pipe_skid_buf` (params WIDTH, SKID) holds the handshake and valid logic for an opaque payload. `ex_mem_skid` packs/unpacks the payload, applies bubble gating to the control bits, and exports occupancy.

## Test plan
- Reset mid-stream: hold 2 entries, assert reset -> same cycle out_valid=0, all outputs 0, in_ready=1, occupancy=0.
- Streaming (out_ready=1): 8 back-to-back accepts with result_in=1..8 -> result_out=1..8 on consecutive cycles, one cycle later, no gaps.
- Backpressure (SKID=1): out_ready=0, push A (result=0xA), B (0xB), C -> in_ready=0 after B, C held; occupancy=2. Release out_ready -> pops A, B, C in order.
- Flush with accept: occupancy=2, flush=1 and in_valid=1 same cycle -> next cycle out_valid=0, mem_write_out=0, reg_write_out=0, occupancy=0.
- Bubble gating: accept entry with reg_write=1, mem_write=1, then pop with no new input -> reg_write_out=0, mem_write_out=0, result_out unchanged.
- SKID=0 build: out_ready=0 with main full -> in_ready=0 combinationally; out_ready=1 -> in_ready=1 same cycle, and the new entry replaces the popped one.
